// File: rtl/jt1943_romrq_arb.sv
// Round-robin arbiter sharing one SDRAM read port among four ROM request clients.
// Grant one edge after req; slot_we one edge after data_rdy; one transaction outstanding at a time.
module jt1943_romrq_arb #(
    parameter int            AW        = 22,
    parameter logic [AW-1:0] SLOT0_OFF = '0,
    parameter logic [AW-1:0] SLOT1_OFF = '0,
    parameter logic [AW-1:0] SLOT2_OFF = '0,
    parameter logic [AW-1:0] SLOT3_OFF = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      slot_req,
    input  logic [4*AW-1:0] slot_addr,
    output logic [3:0]      slot_we,
    output logic [31:0]     slot_dout,
    output logic            sdram_req,
    output logic [AW-1:0]   sdram_addr,
    input  logic            sdram_ack,
    input  logic            data_rdy,
    input  logic [31:0]     data_read,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA, HOLD} state_t;

    state_t        state;
    logic [1:0]    rr;
    logic [1:0]    gnt;
    logic [AW-1:0] addr_l;

    logic [AW-1:0] req_addr [4];
    logic [AW-1:0] offs     [4];
    logic [1:0]    pick;
    logic [1:0]    idx;
    logic          pick_vld;
    logic          deliver;
    logic          addr_match;

    assign offs[0] = SLOT0_OFF;
    assign offs[1] = SLOT1_OFF;
    assign offs[2] = SLOT2_OFF;
    assign offs[3] = SLOT3_OFF;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            req_addr[k] = slot_addr[k*AW +: AW];
        end
    end

    // Grants are only issued from IDLE, so the slot masked during HOLD never wins.
    always_comb begin
        pick_vld = 1'b0;
        pick     = 2'd0;
        idx      = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = rr + 2'(k);
            if (!pick_vld && slot_req[idx]) begin
                pick_vld = 1'b1;
                pick     = idx;
            end
        end
    end

    // Same-cycle ack+data in WAIT_ACK is delivered exactly as if data came in WAIT_DATA.
    assign deliver    = data_rdy && ((state == WAIT_DATA) || (state == WAIT_ACK && sdram_ack));
    assign addr_match = (req_addr[gnt] == addr_l);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr         <= 2'd0;
            gnt        <= 2'd0;
            addr_l     <= '0;
            sdram_addr <= '0;
            sdram_req  <= 1'b0;
            slot_we    <= 4'd0;
            slot_dout  <= 32'd0;
        end else begin
            slot_we <= 4'd0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        gnt        <= pick;
                        addr_l     <= req_addr[pick];
                        sdram_addr <= req_addr[pick] + offs[pick];
                        sdram_req  <= 1'b1;
                        rr         <= pick + 2'd1;
                        state      <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (sdram_ack) begin
                        sdram_req <= 1'b0;
                        state     <= WAIT_DATA;
                    end
                end
                WAIT_DATA: ;
                HOLD:      state <= IDLE;
                default:   state <= IDLE;
            endcase
            // A client that moved to another address gets nothing; it will re-request.
            if (deliver) begin
                if (addr_match) begin
                    slot_we   <= 4'b0001 << gnt;
                    slot_dout <= data_read;
                    state     <= HOLD;
                end else begin
                    state <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_jt1943_romrq_arb.sv
// Bench for jt1943_romrq_arb: scoreboard of expected slot_we/slot_dout plus per-scenario checks.
module tb_jt1943_romrq_arb;
    localparam int AW = 22;
    localparam logic [AW-1:0] OFF0 = 22'h10;
    localparam logic [AW-1:0] OFF1 = 22'h100;
    localparam logic [AW-1:0] OFF2 = 22'h20000;
    localparam logic [AW-1:0] OFF3 = 22'h3FFFFF;

    logic            clk;
    logic            rst;
    logic [3:0]      slot_req;
    logic [4*AW-1:0] slot_addr;
    logic [3:0]      slot_we;
    logic [31:0]     slot_dout;
    logic            sdram_req;
    logic [AW-1:0]   sdram_addr;
    logic            sdram_ack;
    logic            data_rdy;
    logic [31:0]     data_read;
    logic            busy;

    typedef struct {
        logic [3:0]  we;
        logic [31:0] dat;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    jt1943_romrq_arb #(
        .AW(AW), .SLOT0_OFF(OFF0), .SLOT1_OFF(OFF1), .SLOT2_OFF(OFF2), .SLOT3_OFF(OFF3)
    ) dut (
        .clk(clk), .rst(rst), .slot_req(slot_req), .slot_addr(slot_addr),
        .slot_we(slot_we), .slot_dout(slot_dout), .sdram_req(sdram_req),
        .sdram_addr(sdram_addr), .sdram_ack(sdram_ack), .data_rdy(data_rdy),
        .data_read(data_read), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Every strobe the DUT produces must match the next scoreboard entry.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (slot_we !== 4'd0) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_we got we=%b dout=%h want no strobe", slot_we, slot_dout);
            end else begin
                e = sb.pop_front();
                if (slot_we !== e.we || slot_dout !== e.dat) begin
                    errors++;
                    $display("FAIL sb_delivery got we=%b dout=%h want we=%b dout=%h",
                             slot_we, slot_dout, e.we, e.dat);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int s, input logic [AW-1:0] a);
        slot_addr[s*AW +: AW] = a;
    endtask

    function automatic logic [AW-1:0] off_of(input int s);
        case (s)
            0:       return OFF0;
            1:       return OFF1;
            2:       return OFF2;
            default: return OFF3;
        endcase
    endfunction

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (sdram_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        slot_req = 4'd0;
        sdram_ack = 1'b0;
        data_rdy = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        slot_req = 4'hF;
        slot_addr = '0;
        sdram_ack = 1'b0;
        data_rdy = 1'b0;
        data_read = 32'h0;
        tick();
        tick();
        checks++;
        if (slot_we !== 4'd0 || slot_dout !== 32'd0 || sdram_req !== 1'b0 ||
            sdram_addr !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got we=%b dout=%h req=%b addr=%h busy=%b want all zero",
                     slot_we, slot_dout, sdram_req, sdram_addr, busy);
        end
        slot_req = 4'd0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        set_addr(2, 22'h100);
        slot_req = 4'b0100;
        tick();
        checks++;
        if (sdram_req !== 1'b1 || sdram_addr !== 22'h020100 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_grant got req=%b addr=%h busy=%b want 1 020100 1",
                     sdram_req, sdram_addr, busy);
        end
        // data_rdy without ack must be ignored
        data_rdy = 1'b1;
        data_read = 32'h11111111;
        tick();
        data_rdy = 1'b0;
        checks++;
        if (sdram_req !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stray_data got req=%b busy=%b want 1 1", sdram_req, busy);
        end
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        checks++;
        if (sdram_req !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ack_drop got req=%b busy=%b want 0 1", sdram_req, busy);
        end
        data_rdy = 1'b1;
        data_read = 32'hDEADBEEF;
        sb.push_back('{4'b0100, 32'hDEADBEEF});
        tick();
        data_rdy = 1'b0;
        checks++;
        if (slot_we !== 4'b0100 || slot_dout !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_we got we=%b dout=%h want 0100 deadbeef", slot_we, slot_dout);
        end
        tick();
        slot_req = 4'd0;
        checks++;
        if (slot_we !== 4'd0 || slot_dout !== 32'hDEADBEEF || busy !== 1'b0 || sdram_req !== 1'b0) begin
            errors++;
            $display("FAIL hold_mask got we=%b dout=%h busy=%b req=%b want 0000 deadbeef 0 0",
                     slot_we, slot_dout, busy, sdram_req);
        end
        tick();
        tick();
        checks++;
        if (sdram_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL no_regrant got req=%b busy=%b want 0 0", sdram_req, busy);
        end
    endtask

    task automatic test_round_robin();
        logic [AW-1:0] base;
        logic [AW-1:0] ea;
        bit ok;
        int s;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            base = 22'h1000 * AW'(k + 1);
            set_addr(k, base);
        end
        slot_req = 4'hF;
        for (int i = 0; i < 5; i++) begin
            s = i % 4;
            wait_grant(ok);
            base = 22'h1000 * AW'(s + 1);
            ea = base + off_of(s);
            checks++;
            if (!ok || sdram_addr !== ea) begin
                errors++;
                $display("FAIL rr_grant%0d got req=%b addr=%h want 1 %h", i, sdram_req, sdram_addr, ea);
            end
            sdram_ack = 1'b1;
            tick();
            sdram_ack = 1'b0;
            data_rdy = 1'b1;
            data_read = 32'hA0000000 + 32'(i);
            sb.push_back('{4'b0001 << s, 32'hA0000000 + 32'(i)});
            tick();
            data_rdy = 1'b0;
            tick();
            slot_req[s] = 1'b0;
            tick();
            slot_req[s] = 1'b1;
        end
        do_reset();
    endtask

    task automatic test_addr_change();
        bit ok;
        set_addr(1, 22'h40);
        slot_req = 4'b0010;
        wait_grant(ok);
        checks++;
        if (!ok || sdram_addr !== 22'h140) begin
            errors++;
            $display("FAIL chg_grant got req=%b addr=%h want 1 000140", sdram_req, sdram_addr);
        end
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        set_addr(1, 22'h44);
        data_rdy = 1'b1;
        data_read = 32'h55555555;
        tick();
        data_rdy = 1'b0;
        checks++;
        if (slot_we !== 4'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL chg_discard got we=%b busy=%b want 0000 0", slot_we, busy);
        end
        wait_grant(ok);
        checks++;
        if (!ok || sdram_addr !== 22'h144) begin
            errors++;
            $display("FAIL chg_regrant got req=%b addr=%h want 1 000144", sdram_req, sdram_addr);
        end
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        data_rdy = 1'b1;
        data_read = 32'h44444444;
        sb.push_back('{4'b0010, 32'h44444444});
        tick();
        data_rdy = 1'b0;
        tick();
        slot_req = 4'd0;
        tick();
        tick();
    endtask

    task automatic test_same_cycle_wrap();
        bit ok;
        set_addr(3, 22'h2);
        slot_req = 4'b1000;
        wait_grant(ok);
        checks++;
        if (!ok || sdram_addr !== 22'h000001) begin
            errors++;
            $display("FAIL wrap_addr got req=%b addr=%h want 1 000001", sdram_req, sdram_addr);
        end
        sdram_ack = 1'b1;
        data_rdy = 1'b1;
        data_read = 32'hCAFEF00D;
        sb.push_back('{4'b1000, 32'hCAFEF00D});
        tick();
        sdram_ack = 1'b0;
        data_rdy = 1'b0;
        checks++;
        if (slot_we !== 4'b1000 || busy !== 1'b1 || sdram_req !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle got we=%b busy=%b req=%b want 1000 1 0", slot_we, busy, sdram_req);
        end
        tick();
        slot_req = 4'd0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_idle got busy=%b want 0", busy);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bit ok;
        set_addr(0, 22'h200);
        slot_req = 4'b0001;
        wait_grant(ok);
        checks++;
        if (!ok || sdram_addr !== 22'h210) begin
            errors++;
            $display("FAIL mid_grant got req=%b addr=%h want 1 000210", sdram_req, sdram_addr);
        end
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        rst = 1'b1;
        slot_req = 4'd0;
        tick();
        rst = 1'b0;
        checks++;
        if (slot_we !== 4'd0 || slot_dout !== 32'd0 || sdram_req !== 1'b0 ||
            sdram_addr !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got we=%b dout=%h req=%b addr=%h busy=%b want all zero",
                     slot_we, slot_dout, sdram_req, sdram_addr, busy);
        end
        data_rdy = 1'b1;
        data_read = 32'h12345678;
        tick();
        data_rdy = 1'b0;
        checks++;
        if (slot_we !== 4'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL late_data got we=%b busy=%b want 0000 0", slot_we, busy);
        end
        set_addr(0, 22'h204);
        slot_req = 4'b0001;
        wait_grant(ok);
        checks++;
        if (!ok || sdram_addr !== 22'h214) begin
            errors++;
            $display("FAIL post_reset_grant got req=%b addr=%h want 1 000214", sdram_req, sdram_addr);
        end
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        data_rdy = 1'b1;
        data_read = 32'h0BADF00D;
        sb.push_back('{4'b0001, 32'h0BADF00D});
        tick();
        data_rdy = 1'b0;
        checks++;
        if (slot_we !== 4'b0001 || slot_dout !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL post_reset_we got we=%b dout=%h want 0001 0badf00d", slot_we, slot_dout);
        end
        tick();
        slot_req = 4'd0;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_addr_change();
        test_same_cycle_wrap();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
